// File: rtl/ctrl_pipe.sv
// ctrl_pipe: chain of DEPTH registered control-word stages (EX, MEM, WB by
// default) between instruction decode and the datapath.
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-high reset
//   ctrl_in     decoded control word from ID
//   valid_in    ctrl_in carries a real instruction
//   hazard      insert a bubble into stage 0 (load-use)
//   hold        freeze every stage (global stall)
//   flush_mask  bit k squashes stage k on this edge
//   ctrl_out    stage k at bits [k*CTRL_W +: CTRL_W]
//   valid_out   bit k set when stage k holds a real instruction
//   bubble_cnt  saturating count of hazard bubbles (CTRL_PIPE_STATS_EN only)
//
// Build option: define CTRL_PIPE_STATS_EN to add the bubble_cnt port and its
// counter. Without it the port and the counter do not exist.
//
// Edge priority: reset > hold > flush_mask > hazard > normal load.

module ctrl_pipe #(
  parameter int                CTRL_W  = 9,
  parameter int                DEPTH   = 3,
  parameter logic [CTRL_W-1:0] NOP_VAL = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CTRL_W-1:0]         ctrl_in,
  input  logic                      valid_in,
  input  logic                      hazard,
  input  logic                      hold,
  input  logic [DEPTH-1:0]          flush_mask,
  output logic [DEPTH*CTRL_W-1:0]   ctrl_out,
  output logic [DEPTH-1:0]          valid_out
`ifdef CTRL_PIPE_STATS_EN
  ,
  output logic [15:0]               bubble_cnt
`endif
);

  logic [CTRL_W-1:0] stage_q [DEPTH];
  logic [CTRL_W-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;

  // Every stage that becomes invalid is loaded with NOP_VAL, and a copy of an
  // invalid stage is itself NOP_VAL, so an invalid stage never shows stale
  // control bits on ctrl_out.
  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    if (!hold) begin
      if (flush_mask[0] || hazard || !valid_in) begin
        stage_d[0] = NOP_VAL;
        valid_d[0] = 1'b0;
      end else begin
        stage_d[0] = ctrl_in;
        valid_d[0] = 1'b1;
      end
      // Each stage takes its predecessor's pre-edge value, so a flush of
      // stage k-1 on the same edge does not reach stage k.
      for (int k = 1; k < DEPTH; k++) begin
        if (flush_mask[k]) begin
          stage_d[k] = NOP_VAL;
          valid_d[k] = 1'b0;
        end else begin
          stage_d[k] = stage_q[k-1];
          valid_d[k] = valid_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= NOP_VAL;
      end
      valid_q <= '0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    ctrl_out = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ctrl_out[k*CTRL_W +: CTRL_W] = stage_q[k];
    end
  end

  assign valid_out = valid_q;

`ifdef CTRL_PIPE_STATS_EN
  logic [15:0] bubble_cnt_q;
  logic [15:0] bubble_cnt_d;

  // A hazard only counts when it actually displaces a real instruction; a
  // simultaneous flush of stage 0 takes the credit instead.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!hold && !flush_mask[0] && hazard && valid_in &&
        (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;

  logic        clock;
  logic        reset;
  logic [8:0]  ctrl_in;
  logic        valid_in;
  logic        hazard;
  logic        hold;
  logic [2:0]  flush_mask;
  logic [26:0] ctrl_out;
  logic [2:0]  valid_out;
`ifdef CTRL_PIPE_STATS_EN
  logic [15:0] bubble_cnt;
`endif

  int total;
  int bad;

  ctrl_pipe dut (
    .clock      (clock),
    .reset      (reset),
    .ctrl_in    (ctrl_in),
    .valid_in   (valid_in),
    .hazard     (hazard),
    .hold       (hold),
    .flush_mask (flush_mask),
    .ctrl_out   (ctrl_out),
    .valid_out  (valid_out)
`ifdef CTRL_PIPE_STATS_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a list of in-flight instructions, one slot per stage,
  // where an empty slot (valid 0) means a bubble showing an all-zero word.
  int         m_word [3];
  bit         m_full [3];
  int         m_cnt;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_word[k] = 0;
      m_full[k] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_edge();
    int  nw [3];
    bit  nf [3];
    if (hold) return;
    // Everything shifts one slot down the pipe, then flushed slots empty out.
    nw[0] = ctrl_in;
    nf[0] = valid_in && !hazard;
    nw[1] = m_word[0];  nf[1] = m_full[0];
    nw[2] = m_word[1];  nf[2] = m_full[1];
    for (int k = 0; k < 3; k++) begin
      if (flush_mask[k]) nf[k] = 0;
      m_full[k] = nf[k];
      m_word[k] = nf[k] ? nw[k] : 0;
    end
    if (!flush_mask[0] && hazard && valid_in && m_cnt < 65535) m_cnt = m_cnt + 1;
  endtask

  function automatic logic [26:0] exp_ctrl();
    logic [26:0] r;
    r = '0;
    for (int k = 0; k < 3; k++) r[k*9 +: 9] = 9'(m_word[k]);
    return r;
  endfunction

  function automatic logic [2:0] exp_valid();
    return {m_full[2], m_full[1], m_full[0]};
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ctrl_in = '0; valid_in = 0; hazard = 0; hold = 0; flush_mask = '0;
  endtask

  task automatic fill_pipe();
    idle_inputs();
    valid_in = 1;
    ctrl_in = 9'h111; tick();
    ctrl_in = 9'h0F3; tick();
    ctrl_in = 9'h1A5; tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    model_reset();
    #2;
    total++;
    if (ctrl_out !== 27'h0) begin
      bad++; $display("FAIL reset_ctrl: got %h want %h", ctrl_out, 27'h0);
    end
    total++;
    if (valid_out !== 3'b000) begin
      bad++; $display("FAIL reset_valid: got %b want %b", valid_out, 3'b000);
    end
`ifdef CTRL_PIPE_STATS_EN
    total++;
    if (bubble_cnt !== 16'h0) begin
      bad++; $display("FAIL reset_cnt: got %h want 0000", bubble_cnt);
    end
`endif
    @(posedge clock); #1;
    reset = 0;
  endtask

  task automatic test_single();
    logic [26:0] want_c [3];
    logic [2:0]  want_v [3];
    want_c[0] = {9'h000, 9'h000, 9'h1A5}; want_v[0] = 3'b001;
    want_c[1] = {9'h000, 9'h1A5, 9'h000}; want_v[1] = 3'b010;
    want_c[2] = {9'h1A5, 9'h000, 9'h000}; want_v[2] = 3'b100;
    idle_inputs();
    valid_in = 1; ctrl_in = 9'h1A5;
    for (int e = 0; e < 3; e++) begin
      tick();
      idle_inputs();
      total++;
      if (ctrl_out !== want_c[e] || valid_out !== want_v[e]) begin
        bad++;
        $display("FAIL single_edge%0d: got %h/%b want %h/%b", e + 1,
                 ctrl_out, valid_out, want_c[e], want_v[e]);
      end
    end
  endtask

  task automatic test_hazard();
    idle_inputs();
    valid_in = 1; ctrl_in = 9'h0F3; hazard = 1;
    tick();
    total++;
    if (ctrl_out[8:0] !== 9'h000 || valid_out[0] !== 1'b0) begin
      bad++; $display("FAIL hazard_bubble: got %h/%b want 000/0", ctrl_out[8:0], valid_out[0]);
    end
`ifdef CTRL_PIPE_STATS_EN
    total++;
    if (bubble_cnt !== 16'd1) begin
      bad++; $display("FAIL hazard_cnt: got %0d want 1", bubble_cnt);
    end
`endif
    hazard = 0;
    tick();
    total++;
    if (ctrl_out[8:0] !== 9'h0F3 || valid_out[0] !== 1'b1) begin
      bad++; $display("FAIL hazard_release: got %h/%b want 0F3/1", ctrl_out[8:0], valid_out[0]);
    end
    idle_inputs();
  endtask

  task automatic test_hold();
    logic [26:0] frozen;
`ifdef CTRL_PIPE_STATS_EN
    logic [15:0] cnt0;
`endif
    fill_pipe();
    frozen = {9'h111, 9'h0F3, 9'h1A5};
    total++;
    if (ctrl_out !== frozen || valid_out !== 3'b111) begin
      bad++; $display("FAIL hold_fill: got %h/%b want %h/111", ctrl_out, valid_out, frozen);
    end
`ifdef CTRL_PIPE_STATS_EN
    cnt0 = 16'(m_cnt);
`endif
    hold = 1; hazard = 1; flush_mask = 3'b111; valid_in = 1;
    for (int c = 0; c < 3; c++) begin
      ctrl_in = 9'($urandom_range(0, 511));
      tick();
      total++;
      if (ctrl_out !== frozen || valid_out !== 3'b111) begin
        bad++; $display("FAIL hold_cycle%0d: got %h/%b want %h/111", c, ctrl_out, valid_out, frozen);
      end
`ifdef CTRL_PIPE_STATS_EN
      total++;
      if (bubble_cnt !== cnt0) begin
        bad++; $display("FAIL hold_cnt%0d: got %0d want %0d", c, bubble_cnt, cnt0);
      end
`endif
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    fill_pipe();
    flush_mask = 3'b011; valid_in = 1; ctrl_in = 9'h155;
    tick();
    idle_inputs();
    total++;
    if (ctrl_out !== {9'h0F3, 9'h000, 9'h000} || valid_out !== 3'b100) begin
      bad++; $display("FAIL flush_011: got %h/%b want %h/100", ctrl_out, valid_out,
                      {9'h0F3, 9'h000, 9'h000});
    end
  endtask

  task automatic test_async_reset();
    fill_pipe();
    #2;
    reset = 1;
    model_reset();
    #1;
    total++;
    if (ctrl_out !== 27'h0 || valid_out !== 3'b000) begin
      bad++; $display("FAIL async_reset: got %h/%b want 0/000", ctrl_out, valid_out);
    end
    #1;
    reset = 0;
    valid_in = 1; ctrl_in = 9'h0AB;
    tick();
    idle_inputs();
    total++;
    if (ctrl_out !== {9'h000, 9'h000, 9'h0AB} || valid_out !== 3'b001) begin
      bad++; $display("FAIL after_reset: got %h/%b want %h/001", ctrl_out, valid_out,
                      {9'h000, 9'h000, 9'h0AB});
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      ctrl_in    = 9'($urandom_range(0, 511));
      valid_in   = ($urandom_range(0, 3) != 0);
      hazard     = ($urandom_range(0, 3) == 0);
      hold       = ($urandom_range(0, 4) == 0);
      flush_mask = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      tick();
      total++;
      if (ctrl_out !== exp_ctrl() || valid_out !== exp_valid()) begin
        bad++; $display("FAIL random_c%0d: got %h/%b want %h/%b", c, ctrl_out, valid_out,
                        exp_ctrl(), exp_valid());
      end
`ifdef CTRL_PIPE_STATS_EN
      total++;
      if (bubble_cnt !== 16'(m_cnt)) begin
        bad++; $display("FAIL random_cnt%0d: got %0d want %0d", c, bubble_cnt, m_cnt);
      end
`endif
    end
    idle_inputs();
  endtask

`ifdef CTRL_PIPE_STATS_EN
  task automatic test_saturate();
    int errs;
    idle_inputs();
    hazard = 1; valid_in = 1; ctrl_in = 9'h1FF;
    errs = 0;
    for (int c = 0; c < 65540; c++) begin
      tick();
      if (bubble_cnt !== 16'(m_cnt)) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL sat_track: %0d cycles off model", errs);
    end
    total++;
    if (bubble_cnt !== 16'hFFFF) begin
      bad++; $display("FAIL sat_top: got %h want FFFF", bubble_cnt);
    end
    for (int c = 0; c < 4; c++) tick();
    total++;
    if (bubble_cnt !== 16'hFFFF) begin
      bad++; $display("FAIL sat_stay: got %h want FFFF", bubble_cnt);
    end
    idle_inputs();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    reset = 1;
    idle_inputs();
    model_reset();
    test_reset();
    test_single();
    test_hazard();
    test_hold();
    test_flush();
    test_async_reset();
    test_random();
`ifdef CTRL_PIPE_STATS_EN
    test_saturate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter: CTRL_W, 9, control-word width (RegDst, Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite packing); legal 1..64.
REQ-002 Parameter: DEPTH, 3, number of chained control stages (EX, MEM, WB); legal 1..8.
REQ-003 Parameter: NOP_VAL, all-zero CTRL_W vector, control word inserted as a bubble.
REQ-004 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: ctrl_in  input  CTRL_W  decoded control word from ID.
REQ-007 Port: valid_in  input  1  ctrl_in carries a real instruction.
REQ-008 Port: hazard  input  1  insert bubble into stage 0 (load-use).
REQ-009 Port: hold  input  1  freeze every stage (global stall).
REQ-010 Port: flush_mask  input  DEPTH  bit k squashes stage k on this edge.
REQ-011 Port: ctrl_out  output  DEPTH*CTRL_W  stage k at bits [k*CTRL_W +: CTRL_W].
REQ-012 Port: valid_out  output  DEPTH  bit k = stage k holds a real instruction.
REQ-013 Port: bubble_cnt  output  16  bubbles inserted by hazard (present only with CTRL_PIPE_STATS_EN).

Function
REQ-014 All outputs registered; ctrl_in reaches stage 0 one edge after presentation, stage k after k+1 edges absent hold/flush.
REQ-015 Per-edge priority: reset > hold > flush_mask > hazard > normal load.
REQ-016 hold=1: every stage and valid bit retains value; flush_mask and hazard ignored that edge; bubble_cnt unchanged.
REQ-017 Stage 0 (hold=0): loads NOP_VAL, valid 0 if flush_mask[0]=1 or hazard=1 or valid_in=0; else loads ctrl_in, valid 1.
REQ-018 Stage k>0 (hold=0): loads NOP_VAL, valid 0 if flush_mask[k]=1; else copies stage k-1 control and valid as they were before the edge.
REQ-019 Flushing stage k does not affect what stage k+1 receives that edge (k+1 takes pre-edge stage k).
REQ-020 A stage with valid 0 always presents exactly NOP_VAL on ctrl_out.
REQ-021 Simultaneous hazard and flush_mask[0]: single NOP inserted; counts as flush, not hazard bubble.
REQ-022 DEPTH=1: only stage 0 exists; REQ-018 vacuous.

Reset
REQ-023 reset=1: immediately, independent of clock, all stages = NOP_VAL, valid_out = 0, bubble_cnt = 0.
REQ-024 Reset deasserted mid-stream: first edge after deassertion behaves as normal load; no pre-reset state survives.

Configuration
REQ-025 Macro CTRL_PIPE_STATS_EN defined: bubble_cnt present; increments by 1 on each edge where hold=0, flush_mask[0]=0, hazard=1 and valid_in=1; saturates at 16'hFFFF.
REQ-026 Macro undefined: bubble_cnt port and counter logic absent; all other behaviour identical.

Verification
REQ-027 Defaults, reset, then valid_in=1, ctrl_in=9'h1A5 one cycle -> stage0=1A5 after edge 1, stage1 after edge 2, stage2 after edge 3, valid_out 001/010/100.
REQ-028 ctrl_in=9'h0F3 valid with hazard=1 -> stage0=000, valid_out[0]=0; bubble_cnt 0->1 (stats build); next cycle hazard=0 -> stage0=0F3.
REQ-029 Pipe full (stages 1A5,0F3,111), hold=1 for 3 cycles with hazard=1, flush_mask=3'b111 -> all stages unchanged, bubble_cnt unchanged.
REQ-030 Pipe full, flush_mask=3'b011 one edge -> stage0=000, stage1=000, stage2=pre-edge stage1, valid_out=3'b100.
REQ-031 Stats build, hazard+valid_in held 65540 cycles -> bubble_cnt=FFFF and stays.
REQ-032 Assert reset asynchronously between edges with pipe full -> ctrl_out=0, valid_out=0 before next edge; after release, normal loading resumes.
